// File: rtl/sync_tracker.sv
// Video sync tracker: delays raw H/V syncs, regenerates the pixel position aligned
// with the delayed syncs, and monitors frame timing to report lock and errors.
module sync_tracker #(
    parameter int TOTAL_COLS  = 800,
    parameter int TOTAL_ROWS  = 525,
    parameter int ACTIVE_COLS = 640,
    parameter int ACTIVE_ROWS = 480,
    parameter int CNT_W       = 10,
    parameter int SYNC_DELAY  = 1,
    parameter bit SYNC_POL    = 1'b1,
    parameter int LOCK_FRAMES = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             Hsync_i,
    input  logic             Vsync_i,
    output logic             Hsync_o,
    output logic             Vsync_o,
    output logic [CNT_W-1:0] col_count_o,
    output logic [CNT_W-1:0] row_count_o,
    output logic             active_o,
    output logic             line_start_o,
    output logic             frame_start_o,
    output logic             locked_o,
    output logic             frame_err_o
);

    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(TOTAL_COLS - 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(TOTAL_ROWS - 1);
    localparam logic [CNT_W-1:0] ACT_COLS = CNT_W'(ACTIVE_COLS);
    localparam logic [CNT_W-1:0] ACT_ROWS = CNT_W'(ACTIVE_ROWS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [3:0]       LOCK_CNT = 4'(LOCK_FRAMES);

    logic [SYNC_DELAY-1:0] hs_q, vs_q;
    logic [SYNC_DELAY:0]   hs_tap, vs_tap;
    logic [CNT_W-1:0]      col_q, row_q, col_nxt, row_nxt;
    logic [3:0]            good_cnt_q;
    logic                  aligned_q, frame_start_q, frame_err_q;
    logic                  frame_edge, frame_end, good_frame, bad_frame;

    // Tap k of each chain is pipeline stage s[k]; tap 0 is the raw input.
    assign hs_tap = {hs_q, Hsync_i};
    assign vs_tap = {vs_q, Vsync_i};

    assign frame_edge = (vs_tap[SYNC_DELAY-1] == SYNC_POL) && (vs_tap[SYNC_DELAY] != SYNC_POL);
    assign frame_end  = (col_q == COL_LAST) && (row_q == ROW_LAST);

    // Frame quality is only judged once the first edge has aligned the counters;
    // a frame is bad whenever an edge and the frame end fail to coincide.
    assign good_frame = aligned_q && frame_edge && frame_end;
    assign bad_frame  = aligned_q && (frame_edge != frame_end);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        col_nxt = col_q + CNT_ONE;
        row_nxt = row_q;
        if (frame_edge) begin
            col_nxt = '0;
            row_nxt = '0;
        end else if (col_q == COL_LAST) begin
            col_nxt = '0;
            row_nxt = (row_q == ROW_LAST) ? '0 : row_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hs_q          <= {SYNC_DELAY{~SYNC_POL}};
            vs_q          <= {SYNC_DELAY{~SYNC_POL}};
            col_q         <= '0;
            row_q         <= '0;
            aligned_q     <= 1'b0;
            frame_start_q <= 1'b0;
            frame_err_q   <= 1'b0;
            good_cnt_q    <= '0;
        end else begin
            // NOTE: non-blocking so every stage samples its predecessor's pre-edge value.
            hs_q          <= hs_tap[SYNC_DELAY-1:0];
            vs_q          <= vs_tap[SYNC_DELAY-1:0];
            col_q         <= col_nxt;
            row_q         <= row_nxt;
            frame_start_q <= (col_nxt == '0) && (row_nxt == '0);
            frame_err_q   <= bad_frame;
            if (frame_edge) begin
                aligned_q <= 1'b1;
            end
            if (bad_frame) begin
                good_cnt_q <= '0;
            end else if (good_frame && (good_cnt_q != LOCK_CNT)) begin
                good_cnt_q <= good_cnt_q + 4'd1;
            end
        end
    end

    assign Hsync_o       = hs_tap[SYNC_DELAY];
    assign Vsync_o       = vs_tap[SYNC_DELAY];
    assign col_count_o   = col_q;
    assign row_count_o   = row_q;
    assign active_o      = (col_q < ACT_COLS) && (row_q < ACT_ROWS);
    assign line_start_o  = (col_q == '0);
    assign frame_start_o = frame_start_q;
    assign frame_err_o   = frame_err_q;
    assign locked_o      = (good_cnt_q == LOCK_CNT);

endmodule

// File: tb/tb_sync_tracker.sv
// Bench for sync_tracker: two instances (1-cycle active-high, 3-cycle active-low)
// driven from one small video source and checked every cycle against a reference model.
module tb_sync_tracker;

    localparam int TC   = 20;
    localparam int TR   = 12;
    localparam int AC   = 16;
    localparam int AR   = 10;
    localparam int CW   = 5;
    localparam int LOCK = 2;
    localparam int VW   = 2*CW + 7;

    // Expected outputs while reset is asserted: syncs inactive, counters (0,0) so
    // active/line_start decode high, all registered flags low.
    localparam logic [VW-1:0] RST_A = {2'b00, {2*CW{1'b0}}, 5'b11000};
    localparam logic [VW-1:0] RST_B = {2'b11, {2*CW{1'b0}}, 5'b11000};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic hs_a = 1'b0, vs_a = 1'b0, hs_b = 1'b1, vs_b = 1'b1;

    logic          hso_a, vso_a, act_a, ls_a, fs_a, lock_a, err_a;
    logic          hso_b, vso_b, act_b, ls_b, fs_b, lock_b, err_b;
    logic [CW-1:0] col_a, row_a, col_b, row_b;
    logic [VW-1:0] obs_a, obs_b;

    assign obs_a = {hso_a, vso_a, col_a, row_a, act_a, ls_a, fs_a, lock_a, err_a};
    assign obs_b = {hso_b, vso_b, col_b, row_b, act_b, ls_b, fs_b, lock_b, err_b};

    sync_tracker #(
        .TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR),
        .CNT_W(CW), .SYNC_DELAY(1), .SYNC_POL(1'b1), .LOCK_FRAMES(LOCK)
    ) dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .Hsync_i(hs_a), .Vsync_i(vs_a),
        .Hsync_o(hso_a), .Vsync_o(vso_a), .col_count_o(col_a), .row_count_o(row_a),
        .active_o(act_a), .line_start_o(ls_a), .frame_start_o(fs_a),
        .locked_o(lock_a), .frame_err_o(err_a)
    );

    sync_tracker #(
        .TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR),
        .CNT_W(CW), .SYNC_DELAY(3), .SYNC_POL(1'b0), .LOCK_FRAMES(LOCK)
    ) dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .Hsync_i(hs_b), .Vsync_i(vs_b),
        .Hsync_o(hso_b), .Vsync_o(vso_b), .col_count_o(col_b), .row_count_o(row_b),
        .active_o(act_b), .line_start_o(ls_b), .frame_start_o(fs_b),
        .locked_o(lock_b), .frame_err_o(err_b)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int err_cnt[2];
    int fs_cnt[2];

    // Reference model state, index 0 = dut_a, 1 = dut_b.
    logic [1:0] q_a[$];
    logic [1:0] q_b[$];
    int   m_col[2], m_row[2], m_good[2];
    bit   m_seen[2], m_fs[2], m_err[2];
    logic m_hout[2], m_vout[2];

    task automatic check(input string tag, input logic [VW-1:0] observed, input logic [VW-1:0] expected);
        vectors++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [VW-1:0] exp_vec(input int i);
        logic act;
        act = (m_col[i] < AC) && (m_row[i] < AR);
        return {m_hout[i], m_vout[i], CW'(m_col[i]), CW'(m_row[i]), act,
                (m_col[i] == 0), m_fs[i], (m_good[i] == LOCK), m_err[i]};
    endfunction

    task automatic reset_model();
        for (int i = 0; i < 2; i++) begin
            m_col[i]  = 0;
            m_row[i]  = 0;
            m_good[i] = 0;
            m_seen[i] = 1'b0;
            m_fs[i]   = 1'b0;
            m_err[i]  = 1'b0;
        end
        m_hout[0] = 1'b0; m_vout[0] = 1'b0;
        m_hout[1] = 1'b1; m_vout[1] = 1'b1;
        q_a.delete();
        q_b.delete();
    endtask

    // Sync inputs are queued when driven and popped when they are due at the
    // output; a frame edge is the clock at which the expected Vsync_o turns active.
    task automatic model_step(input int i, input logic h, input logic v);
        logic [1:0] nxt;
        logic       pol;
        int         d;
        bit         fe, at_end, bad, good;
        pol = (i == 0) ? 1'b1 : 1'b0;
        d   = (i == 0) ? 1 : 3;
        nxt = {~pol, ~pol};
        if (i == 0) begin
            q_a.push_back({h, v});
            if (q_a.size() >= d) nxt = q_a.pop_front();
        end else begin
            q_b.push_back({h, v});
            if (q_b.size() >= d) nxt = q_b.pop_front();
        end
        fe     = (nxt[0] == pol) && (m_vout[i] != pol);
        at_end = (m_col[i] == TC-1) && (m_row[i] == TR-1);
        bad    = m_seen[i] && (fe != at_end);
        good   = m_seen[i] && fe && at_end;
        if (fe) m_seen[i] = 1'b1;
        if (fe) begin
            m_col[i] = 0;
            m_row[i] = 0;
        end else if (m_col[i] == TC-1) begin
            m_col[i] = 0;
            m_row[i] = (m_row[i] == TR-1) ? 0 : m_row[i] + 1;
        end else begin
            m_col[i] = m_col[i] + 1;
        end
        m_fs[i]  = (m_col[i] == 0) && (m_row[i] == 0);
        m_err[i] = bad;
        if (bad) m_good[i] = 0;
        else if (good && m_good[i] < LOCK) m_good[i] = m_good[i] + 1;
        m_hout[i] = nxt[1];
        m_vout[i] = nxt[0];
    endtask

    // Drive one pixel at the falling edge, let one rising edge pass, compare.
    task automatic cycle(input logic h, input logic v);
        hs_a = h;  vs_a = v;
        hs_b = ~h; vs_b = ~v;
        model_step(0, h, v);
        model_step(1, ~h, ~v);
        @(negedge clk);
        check("cycle_a", obs_a, exp_vec(0));
        check("cycle_b", obs_b, exp_vec(1));
        err_cnt[0] += int'(err_a);
        err_cnt[1] += int'(err_b);
        fs_cnt[0]  += int'(fs_a);
        fs_cnt[1]  += int'(fs_b);
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_a", obs_a, RST_A);
        check("rst_async_b", obs_b, RST_B);
        reset_model();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One source frame: Hsync active for 3 pixels per line, Vsync active for row 0.
    task automatic src_frame(input int rows, input bit with_vs, input int rst_row);
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < TC; c++) begin
                cycle(c < 3, with_vs && (r == 0));
                if (r == rst_row && c == TC/2) async_reset();
            end
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 2; i++) begin
            err_cnt[i] = 0;
            fs_cnt[i]  = 0;
        end
    endtask

    task automatic lock_check(input string tag, input logic expected);
        check({tag, "_a"}, VW'(lock_a), VW'(expected));
        check({tag, "_b"}, VW'(lock_b), VW'(expected));
    endtask

    task automatic err_check(input string tag, input int expected);
        check({tag, "_a"}, VW'(err_cnt[0]), VW'(expected));
        check({tag, "_b"}, VW'(err_cnt[1]), VW'(expected));
    endtask

    initial begin
        reset_model();
        clear_counts();
        repeat (3) @(negedge clk);
        check("reset_a", obs_a, RST_A);
        check("reset_b", obs_b, RST_B);
        rst_n = 1'b1;

        // Ideal timing, Vsync already active at release: initial edge then two good ones.
        src_frame(TR, 1'b1, -1);
        src_frame(TR, 1'b1, -1);
        lock_check("lock_after_2_edges", 1'b0);
        src_frame(TR, 1'b1, -1);
        lock_check("lock_after_3_edges", 1'b1);
        err_check("no_err_ideal", 0);
        src_frame(TR, 1'b1, -1);

        // One frame one row short.
        clear_counts();
        src_frame(TR-1, 1'b1, -1);
        src_frame(TR, 1'b1, -1);
        err_check("err_short_frame", 1);
        lock_check("unlock_short_frame", 1'b0);
        src_frame(TR, 1'b1, -1);
        lock_check("relock_short_1good", 1'b0);
        src_frame(TR, 1'b1, -1);
        lock_check("relock_short_2good", 1'b1);

        // One frame with Vsync missing: error at the natural wrap, free-run through (0,0).
        clear_counts();
        src_frame(TR, 1'b0, -1);
        err_check("err_missing_vs", 1);
        check("fs_free_run_a", VW'(fs_cnt[0]), VW'(1));
        check("fs_free_run_b", VW'(fs_cnt[1]), VW'(1));
        lock_check("unlock_missing_vs", 1'b0);
        src_frame(TR, 1'b1, -1);
        lock_check("relock_vs_1good", 1'b0);
        src_frame(TR, 1'b1, -1);
        lock_check("relock_vs_2good", 1'b1);

        // Reset mid-frame while locked.
        src_frame(TR, 1'b1, TR/2);
        lock_check("lock_after_reset", 1'b0);
        src_frame(TR, 1'b1, -1);
        src_frame(TR, 1'b1, -1);
        lock_check("relock_rst_1good", 1'b0);
        src_frame(TR, 1'b1, -1);
        lock_check("relock_rst_2good", 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
